regfile_shadow_tap: RTL

- Parametrised successor to the fixed 32x32 register-file tap used by the debug/insight path.
- Maintains a shadow copy of the integer register file by observing the core's writeback port, instead of probing the core hierarchically.
- Takes atomic snapshots on request and streams them out one register per beat over a valid/ready interface.
- Also provides a registered random-access read of the live shadow.
- Sits beside the core in the insight subsystem and feeds the trace/debug formatter.

---
 rtl/regfile_shadow_tap.sv | 114 +++++++++++
 1 files changed

// File: rtl/regfile_shadow_tap.sv
// Shadow copy of the integer register file built from writeback traffic; rd_data has 1-cycle latency.
// Snapshots stream out one register per beat on valid/ready; beats hold steady while out_ready is low.
module regfile_shadow_tap #(
  parameter int  XLEN     = 32,
  parameter int  NREGS    = 32,
  parameter bit  ZERO_REG = 1'b1,
  localparam int IW       = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [IW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            snap_req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            overrun,
  input  logic            overrun_clr,
  input  logic [IW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

  typedef enum logic {IDLE, DUMP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] shadow   [NREGS];
  logic [XLEN-1:0] snapshot [NREGS];
  logic            wr_en;
  logic            hs;
  logic            snap_take;

  // Writes to a hardwired-zero x0 never reach the shadow, so every read path sees 0 there.
  assign wr_en     = wb_valid && !(ZERO_REG && (wb_addr == '0));
  assign hs        = out_valid && out_ready;
  assign snap_take = (state == IDLE) && snap_req;
  assign out_data  = snapshot[out_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      shadow[wb_addr] <= wb_data;
    end
  end

  // Snapshot folds in a same-cycle writeback so the capture is atomic with respect to the core.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) snapshot[i] <= '0;
    end else if (snap_take) begin
      for (int i = 0; i < NREGS; i++)
        snapshot[i] <= (wr_en && (wb_addr == IW'(i))) ? wb_data : shadow[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (snap_req)          state_nxt = DUMP;
      DUMP: if (hs && out_last)    state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    if (state == DUMP) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = (out_idx == LAST_IDX);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= hs && out_last;
      if (snap_take)   out_idx <= '0;
      else if (hs)     out_idx <= out_last ? '0 : out_idx + IW'(1);
    end
  end

  // A request that lands while busy (final beat included) sets the flag even if a clear is pending.
  always_ff @(posedge clock) begin
    if (reset)                 overrun <= 1'b0;
    else if (snap_req && busy) overrun <= 1'b1;
    else if (overrun_clr)      overrun <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset)                                rd_data <= '0;
    else if (ZERO_REG && (rd_addr == '0))     rd_data <= '0;
    else if (wr_en && (wb_addr == rd_addr))   rd_data <= wb_data;
    else                                      rd_data <= shadow[rd_addr];
  end

endmodule
